fp_mul_issue: RTL and testbench
===============================

Name: fp_mul_issue

Overview:
- Host-side partner of fp_mul: drives its operand inputs and consumes its result outputs.
- Accepts packed IEEE-754 single-precision operand pairs on a valid/ready stream, unpacks them and drives src_valid/a_*/b_* into fp_mul.
- Captures fp_mul results (dst_valid/r_*) into a result FIFO and repacks them onto a valid/ready output stream.
- fp_mul has no backpressure, so issue is credit-gated: an operation is accepted only when FIFO space is guaranteed for its result, whatever the fp_mul pipeline latency.

Parameters:
- DEPTH, 8, result FIFO entries and total credits; power of 2, minimum 2.
- CW, $clog2(DEPTH+1), width of the credit/in-flight counters (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid && in_ready
- in_a  in  32  operand A, IEEE-754 {sign, exp[7:0], man[22:0]}
- in_b  in  32  operand B, same format
- src_valid  out  1  to fp_mul: operation strobe
- a_man  out  23  to fp_mul
- a_exp  out  8  to fp_mul
- a_sign  out  1  to fp_mul
- b_man  out  23  to fp_mul
- b_exp  out  8  to fp_mul
- b_sign  out  1  to fp_mul
- r_man  in  23  from fp_mul
- r_exp  in  8  from fp_mul
- r_sign  in  1  from fp_mul
- dst_valid  in  1  from fp_mul: result strobe
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  32  result {r_sign, r_exp, r_man}
- inflight  out  CW  operations issued whose result has not yet arrived
- err  out  1  sticky protocol error

Behaviour:
- Reset (async assert, sync release): src_valid=0; a_*/b_* = 0; FIFO empty; out_valid=0; out_data=0; used=0; inflight=0; err=0. in_ready=1 after release.
- Credit counter used (CW bits) = inflight + FIFO occupancy.
  - in_ready = (used < DEPTH), combinational from registers only; no dependence on in_valid.
  - Accept: used+1. Pop (out_valid && out_ready): used-1. Both in the same cycle: used unchanged.
- Issue path is a registered stage with 1-cycle latency.
  - On accept in cycle N, cycle N+1 shows src_valid=1, a_sign=in_a[31], a_exp=in_a[30:23], a_man=in_a[22:0]; b_* likewise from in_b.
  - Without an accept, src_valid=0 the next cycle and a_*/b_* hold their last values.
  - Back-to-back accepts produce back-to-back src_valid pulses.
- inflight: +1 on each src_valid cycle, -1 on each dst_valid cycle; both in the same cycle leaves it unchanged.
- Result path:
  - dst_valid pushes {r_sign, r_exp, r_man} into the FIFO in that cycle.
  - The FIFO is first-word-fall-through: out_valid = !empty and out_data = head entry, registered.
  - A push into an empty FIFO is visible at the output the next cycle.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (the pop frees the slot) and when it is empty (the push lands; out_valid rises next cycle).
  - Read and write pointers are log2(DEPTH) bits and wrap naturally; full/empty use an extra wrap bit or an occupancy count.
- Ordering: results are presented strictly in issue order, since fp_mul is in-order. No data modification, no rounding, no special-value handling here.
- Errors set err=1, which holds until reset:
  - dst_valid while inflight==0: the result is dropped and counters are unchanged.
  - dst_valid while the FIFO is full and there is no simultaneous pop: the result is dropped.
  - With a correct fp_mul, neither condition can occur.
- Reset mid-operation: all state clears immediately. Results fp_mul later returns for pre-reset operations hit inflight==0 and set err. The integrating top must reset fp_mul and this block together.
- out_data is stable while out_valid && !out_ready.

Test Plan:
- Single op, out_ready=1: in_a=0x3FC00000 (1.5), in_b=0x40000000 (2.0) -> next cycle src_valid=1, a_sign=0, a_exp=0x7F, a_man=0x400000, b_exp=0x80, b_man=0; fp_mul returns -> out_data=0x40400000 (3.0), out_valid high for 1 cycle; inflight 1->0; used returns to 0.
- Credit exhaustion, out_ready=0, in_valid held high with distinct operands: exactly 8 accepts; in_ready=0 from the cycle after the 8th accept; exactly 8 src_valid pulses; FIFO fills to 8; no 9th issue.
- Full FIFO, out_ready=1 for one cycle with in_valid=1: one pop plus one accept in the same cycle -> used stays 8; the 9th operation issues; its result arrives in the freed slot in order; err stays 0.
- Streaming with back-to-back accepts and random out_ready: 100 ops -> out_data sequence equals the reference products in issue order; pointers wrap at least 12 times; no loss, duplication or err.
- Spurious dst_valid with r_*=0x7F800000 fields while inflight=0 -> err=1 and stays 1; out_valid stays 0; used stays 0.
- Reset asserted with 3 in flight and 2 queued -> immediately src_valid=0, out_valid=0, inflight=0, in_ready=1 after release; if fp_mul is not reset, its late dst_valid sets err=1.

Source files
------------

// File: rtl/fp_mul_issue.sv
// Host-side issue/return wrapper around fp_mul: credit-gated operand issue,
// result FIFO with registered first-word-fall-through output.
module fp_mul_issue #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic          src_valid,
  output logic [22:0]   a_man,
  output logic [7:0]    a_exp,
  output logic          a_sign,
  output logic [22:0]   b_man,
  output logic [7:0]    b_exp,
  output logic          b_sign,
  input  logic [22:0]   r_man,
  input  logic [7:0]    r_exp,
  input  logic          r_sign,
  input  logic          dst_valid,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [CW-1:0] inflight,
  output logic          err
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic          src_valid_r;
  logic [22:0]   a_man_r, b_man_r;
  logic [7:0]    a_exp_r, b_exp_r;
  logic          a_sign_r, b_sign_r;
  logic [CW-1:0] used_r, inflight_r, count_r;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [31:0]   mem_r [DEPTH];
  logic          out_valid_r;
  logic [31:0]   out_data_r;
  logic          err_r;

  logic          in_ready_s, accept_s, pop_s, full_s, dst_ok_s, push_s, drop_s;
  logic [31:0]   r_word_s, head_nx_s;
  logic [CW-1:0] used_nx_s, inflight_nx_s, count_nx_s, remain_s;
  logic [AW-1:0] rd_ptr_nx_s;

  assign in_ready_s = (used_r < DEPTH_C);
  assign accept_s   = in_valid && in_ready_s;
  assign pop_s      = out_valid_r && out_ready;
  assign full_s     = (count_r == DEPTH_C);
  assign r_word_s   = {r_sign, r_exp, r_man};
  // A result with nothing outstanding is never accepted; full FIFO accepts only alongside a pop.
  assign dst_ok_s   = dst_valid && (inflight_r != {CW{1'b0}});
  assign push_s     = dst_ok_s && (!full_s || pop_s);
  assign drop_s     = dst_valid && !push_s;

  // Next-state arithmetic for credits, in-flight count and FIFO head.
  always_comb begin
    used_nx_s     = used_r;
    inflight_nx_s = inflight_r;
    count_nx_s    = count_r;
    rd_ptr_nx_s   = rd_ptr_r;
    remain_s      = count_r;
    head_nx_s     = out_data_r;

    if (accept_s && !pop_s) begin
      used_nx_s = used_r + CNT_ONE;
    end else if (pop_s && !accept_s) begin
      used_nx_s = used_r - CNT_ONE;
    end else begin
      used_nx_s = used_r;
    end

    if (src_valid_r && !dst_ok_s) begin
      inflight_nx_s = inflight_r + CNT_ONE;
    end else if (dst_ok_s && !src_valid_r) begin
      inflight_nx_s = inflight_r - CNT_ONE;
    end else begin
      inflight_nx_s = inflight_r;
    end

    if (push_s && !pop_s) begin
      count_nx_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nx_s = count_r - CNT_ONE;
    end else begin
      count_nx_s = count_r;
    end

    if (pop_s) begin
      rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
      remain_s    = count_r - CNT_ONE;
    end else begin
      rd_ptr_nx_s = rd_ptr_r;
      remain_s    = count_r;
    end

    // When nothing survives the pop, the incoming result becomes the new head directly.
    if (remain_s == {CW{1'b0}}) begin
      head_nx_s = r_word_s;
    end else begin
      head_nx_s = mem_r[rd_ptr_nx_s];
    end
  end

  // Operand issue stage: one-cycle registered unpack into fp_mul.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_valid_r <= 1'b0;
      a_sign_r    <= 1'b0;
      a_exp_r     <= 8'd0;
      a_man_r     <= 23'd0;
      b_sign_r    <= 1'b0;
      b_exp_r     <= 8'd0;
      b_man_r     <= 23'd0;
    end else begin
      src_valid_r <= accept_s;
      if (accept_s) begin
        a_sign_r <= in_a[31];
        a_exp_r  <= in_a[30:23];
        a_man_r  <= in_a[22:0];
        b_sign_r <= in_b[31];
        b_exp_r  <= in_b[30:23];
        b_man_r  <= in_b[22:0];
      end
    end
  end

  // Result storage array.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= r_word_s;
    end
  end

  // Counters, pointers, registered FIFO head and sticky error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      used_r      <= {CW{1'b0}};
      inflight_r  <= {CW{1'b0}};
      count_r     <= {CW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= 32'd0;
      err_r       <= 1'b0;
    end else begin
      used_r      <= used_nx_s;
      inflight_r  <= inflight_nx_s;
      count_r     <= count_nx_s;
      rd_ptr_r    <= rd_ptr_nx_s;
      out_valid_r <= (count_nx_s != {CW{1'b0}});
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (count_nx_s != {CW{1'b0}}) begin
        out_data_r <= head_nx_s;
      end
      if (drop_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign src_valid = src_valid_r;
  assign a_sign    = a_sign_r;
  assign a_exp     = a_exp_r;
  assign a_man     = a_man_r;
  assign b_sign    = b_sign_r;
  assign b_exp     = b_exp_r;
  assign b_man     = b_man_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign inflight  = inflight_r;
  assign err       = err_r;

endmodule

// File: tb/tb_fp_mul_issue.sv
// Bench for fp_mul_issue: a stand-in fp_mul with fixed latency plus a
// queue-based reference of issued products, credits and FIFO occupancy.
module tb_fp_mul_issue;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int LAT   = 3;

  logic clk = 1'b0;
  logic rstn;
  logic in_valid, in_ready, src_valid, a_sign, b_sign, r_sign, dst_valid;
  logic out_valid, out_ready, err;
  logic [31:0] in_a, in_b, out_data;
  logic [22:0] a_man, b_man, r_man;
  logic [7:0]  a_exp, b_exp, r_exp;
  logic [CW-1:0] inflight;

  always #5 clk = ~clk;

  fp_mul_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .src_valid(src_valid),
    .a_man(a_man), .a_exp(a_exp), .a_sign(a_sign),
    .b_man(b_man), .b_exp(b_exp), .b_sign(b_sign),
    .r_man(r_man), .r_exp(r_exp), .r_sign(r_sign), .dst_valid(dst_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .inflight(inflight), .err(err)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference state
  logic [31:0] ref_q[$];
  int used_m, inflight_m, fifo_m;
  bit err_m, acc_prev, last_acc;
  logic [31:0] a_hold, b_hold;
  int acc_cnt = 0, pop_cnt = 0, src_cnt = 0;

  // stand-in fp_mul pipeline, deliberately not cleared by our reset
  bit pv[LAT];
  logic [31:0] pd[LAT];
  bit inj_v;
  logic [31:0] inj_d;

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [7:0]  e;
    logic [22:0] m;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = a[30:23] + b[30:23] - 8'd127;
    if (p[47]) begin
      e = e + 8'd1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e, m};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic void clear_model();
    ref_q.delete();
    used_m = 0; inflight_m = 0; fifo_m = 0;
    err_m = 1'b0; acc_prev = 1'b0; last_acc = 1'b0;
    a_hold = 32'd0; b_hold = 32'd0;
  endfunction

  // One clock: called at a negedge with in_valid/in_a/in_b/out_ready chosen.
  task automatic cyc();
    bit drv, acc, pop, push, dok;
    logic [31:0] drvd, popd;
    drv  = pv[LAT-1] || inj_v;
    drvd = inj_v ? inj_d : pd[LAT-1];
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = src_valid;
    pd[0] = fmul({a_sign, a_exp, a_man}, {b_sign, b_exp, b_man});
    dst_valid = drv;
    {r_sign, r_exp, r_man} = drvd;

    acc = in_valid && (used_m < DEPTH);
    pop = out_ready && (fifo_m != 0);
    if (pop) begin
      popd = ref_q.pop_front();
      pop_cnt++;
      chk("pop_data", out_data, popd);
    end
    dok  = drv && (inflight_m != 0);
    push = dok && ((fifo_m < DEPTH) || pop);
    if (drv && !push) err_m = 1'b1;
    if (acc) begin
      ref_q.push_back(fmul(in_a, in_b));
      acc_cnt++;
      a_hold = in_a;
      b_hold = in_b;
    end
    used_m     = used_m + int'(acc) - int'(pop);
    inflight_m = inflight_m + int'(acc_prev) - int'(dok);
    fifo_m     = fifo_m + int'(push) - int'(pop);
    acc_prev   = acc;
    last_acc   = acc;

    @(posedge clk);
    @(negedge clk);
    inj_v = 1'b0;
    dst_valid = 1'b0;
    if (src_valid) src_cnt++;
    chk("src_valid", {31'd0, src_valid}, {31'd0, acc});
    chk("a_fields", {a_sign, a_exp, a_man}, a_hold);
    chk("b_fields", {b_sign, b_exp, b_man}, b_hold);
    chk("in_ready", {31'd0, in_ready}, {31'd0, used_m < DEPTH});
    chk("inflight", {28'd0, inflight}, inflight_m);
    chk("out_valid", {31'd0, out_valid}, {31'd0, fifo_m != 0});
    chk("err", {31'd0, err}, {31'd0, err_m});
    if (fifo_m != 0) chk("out_head", out_data, ref_q[0]);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    in_valid = 1'b0;
    dst_valid = 1'b0;
    #1;
    chk("rst_src_valid", {31'd0, src_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_inflight", {28'd0, inflight}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_a_fields", {a_sign, a_exp, a_man}, 32'd0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, a0, s0, p0, ov_cnt;
    logic [31:0] ov_d;
    rstn = 1'b0; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b0;
    dst_valid = 1'b0; r_sign = 1'b0; r_exp = 8'd0; r_man = 23'd0;
    inj_v = 1'b0; inj_d = 32'd0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = 32'd0;
    end
    clear_model();
    @(negedge clk);
    do_reset();

    // single op: 1.5 * 2.0
    in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h40000000; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("t1_a_sign", {31'd0, a_sign}, 32'd0);
    chk("t1_a_exp", {24'd0, a_exp}, 32'h7F);
    chk("t1_a_man", {9'd0, a_man}, 32'h400000);
    chk("t1_b_exp", {24'd0, b_exp}, 32'h80);
    chk("t1_b_man", {9'd0, b_man}, 32'd0);
    ov_cnt = 0; ov_d = 32'd0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (out_valid) begin
        ov_cnt++;
        ov_d = out_data;
      end
    end
    chk("t1_ov_cycles", ov_cnt, 1);
    chk("t1_product", ov_d, 32'h40400000);
    chk("t1_inflight", {28'd0, inflight}, 32'd0);

    // credit exhaustion with the output stalled
    out_ready = 1'b0; a0 = acc_cnt; s0 = src_cnt;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      cyc();
    end
    in_valid = 1'b0;
    n = 0;
    while (fifo_m != DEPTH && n < 20) begin
      cyc();
      n++;
    end
    chk("t2_fill_in_time", {31'd0, n < 20}, 32'd1);
    chk("t2_accepts", acc_cnt - a0, 8);
    chk("t2_src_pulses", src_cnt - s0, 8);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd0);

    // free one slot; the 9th op issues into it
    in_valid = 1'b1; in_a = $urandom; in_b = $urandom; out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    chk("t3_issue9", {31'd0, src_valid}, 32'd1);
    chk("t3_used_full", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (fifo_m != DEPTH && n < 20) begin
      cyc();
      n++;
    end
    chk("t3_refill_in_time", {31'd0, n < 20}, 32'd1);
    chk("t3_err", {31'd0, err}, 32'd0);
    out_ready = 1'b1; n = 0;
    while (fifo_m != 0 && n < 40) begin
      cyc();
      n++;
    end
    chk("t3_drain_in_time", {31'd0, n < 40}, 32'd1);

    // random streaming, 100 ops
    a0 = acc_cnt; p0 = pop_cnt; n = 0;
    while ((acc_cnt - a0) < 100 && n < 3000) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
      n++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    while ((fifo_m != 0 || inflight_m != 0) && n < 3100) begin
      out_ready = ($urandom_range(0, 1) != 0);
      cyc();
      n++;
    end
    chk("t4_in_time", {31'd0, n < 3100}, 32'd1);
    chk("t4_popped", pop_cnt - p0, 100);
    chk("t4_err", {31'd0, err}, 32'd0);

    // spurious result with nothing in flight
    inj_v = 1'b1; inj_d = 32'h7F800000;
    cyc();
    for (int i = 0; i < 3; i++) cyc();
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);

    do_reset();

    // reset with ops in flight and queued; fp_mul left running
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      cyc();
    end
    in_valid = 1'b0; n = 0;
    while (fifo_m != 2 && n < 10) begin
      cyc();
      n++;
    end
    chk("t6_two_queued", {31'd0, n < 10}, 32'd1);
    chk("t6_inflight_pre", {28'd0, inflight}, 32'd3);
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    chk("t6_late_err", {31'd0, err}, 32'd1);
    chk("t6_out_valid", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
